keypad_scan: RTL

Scanned-matrix input front end for the 2048 board: drives the four columns of a 4x4 push-button keypad, samples the four row lines, debounces, and reports one event per key press. It is the input-side counterpart of the row-scanned LED matrix output. It feeds the game controller with a key code and, for the four direction keys, a move command.

---
 rtl/keypad_pkg.sv | 45 ++++
 rtl/keypad_debounce.sv | 125 ++++++++++++
 rtl/keypad_scan.sv | 83 ++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Key code = 4*column + row; a frame is one bit per key, indexed by key code.
package keypad_pkg;

  localparam int KEY_W    = 4;
  localparam int NUM_KEYS = 16;

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM,
    HELD,
    RELEASE
  } kp_state_e;

  typedef enum logic [1:0] {
    FRAME_EMPTY,
    FRAME_SINGLE,
    FRAME_MULTI
  } frame_cls_e;

  localparam logic [1:0] MOVE_UP    = 2'd0;
  localparam logic [1:0] MOVE_DOWN  = 2'd1;
  localparam logic [1:0] MOVE_LEFT  = 2'd2;
  localparam logic [1:0] MOVE_RIGHT = 2'd3;

  function automatic frame_cls_e classify_frame(input logic [NUM_KEYS-1:0] frame);
    int unsigned n;
    n = 0;
    for (int i = 0; i < NUM_KEYS; i++) n += 32'(frame[i]);
    if (n == 0) return FRAME_EMPTY;
    else if (n == 1) return FRAME_SINGLE;
    else return FRAME_MULTI;
  endfunction

  // Only meaningful for a SINGLE frame; returns the lowest set index otherwise.
  function automatic logic [KEY_W-1:0] frame_code(input logic [NUM_KEYS-1:0] frame);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (frame[i]) idx = KEY_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame classification and press/release debounce for the keypad scanner.
// Consumes one complete 16-key frame per frame_done and emits accepted presses.
//
// state   | meaning
// IDLE    | no key accepted, no candidate
// CONFIRM | single key seen, counting matching frames
// HELD    | key accepted, waiting for empty frames
// RELEASE | counting consecutive empty frames
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_done,
  input  logic [NUM_KEYS-1:0] frame,
  output logic                accept,
  output logic [KEY_W-1:0]    code,
  output logic                held
);

  localparam logic [3:0] DB = 4'(DEBOUNCE);

  kp_state_e        state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             accept_q, accept_d;
  logic             held_q, held_d;

  frame_cls_e       cls;
  logic [KEY_W-1:0] fcode;
  logic [3:0]       cnt_inc;

  always_comb begin
    cls      = classify_frame(frame);
    fcode    = frame_code(frame);
    cnt_inc  = cnt_q + 4'd1;
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    code_d   = code_q;
    accept_d = 1'b0;
    if (frame_done) begin
      unique case (state_q)
        IDLE: begin
          if (cls == FRAME_SINGLE) begin
            cand_d = fcode;
            cnt_d  = 4'd1;
            if (DB == 4'd1) begin
              accept_d = 1'b1;
              code_d   = fcode;
              state_d  = HELD;
            end else begin
              state_d = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (cls == FRAME_SINGLE && fcode == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB) begin
              accept_d = 1'b1;
              code_d   = cand_q;
              state_d  = HELD;
            end
          end else begin
            cnt_d   = 4'd0;
            state_d = IDLE;
          end
        end
        HELD: begin
          if (cls == FRAME_EMPTY) begin
            if (DB == 4'd1) begin
              cnt_d   = 4'd0;
              state_d = IDLE;
            end else begin
              cnt_d   = 4'd1;
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (cls == FRAME_EMPTY) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB) begin
              cnt_d   = 4'd0;
              state_d = IDLE;
            end
          end else begin
            // any key activity during release means the key is still down
            cnt_d   = 4'd0;
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    held_d = (state_d == HELD) || (state_d == RELEASE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      cand_q   <= '0;
      code_q   <= '0;
      accept_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      code_q   <= code_d;
      accept_q <= accept_d;
      held_q   <= held_d;
    end
  end

  assign accept = accept_q;
  assign code   = code_q;
  assign held   = held_q;

endmodule

// File: rtl/keypad_scan.sv
// Scanned 4x4 keypad front end: column drive, row synchronizer, frame capture,
// and debounced key/move events for the game controller.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [3:0]       col,
  input  logic [3:0]       row_in,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_code,
  output logic             key_held,
  output logic             move_valid,
  output logic [1:0]       move_dir
);

  localparam int               CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [3:0]          sync1_q, sync1_d;
  logic [3:0]          sync2_q, sync2_d;
  logic [CNT_W-1:0]    slot_q, slot_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [NUM_KEYS-1:0] frame_q, frame_d;
  logic                frame_done_q, frame_done_d;
  logic [1:0]          move_dir_q, move_dir_d;
  logic                tick;

  always_comb begin
    sync1_d      = row_in;
    sync2_d      = sync1_q;
    tick         = (slot_q == CNT_LAST);
    slot_d       = tick ? '0 : slot_q + CNT_W'(1);
    col_idx_d    = tick ? col_idx_q + 2'd1 : col_idx_q;
    frame_d      = frame_q;
    // rows are active-low; sampled at the end of the slot, before the column moves on
    if (tick) frame_d[col_idx_q*4 +: 4] = ~sync2_q;
    frame_done_d = tick && (col_idx_q == 2'd3);
    move_dir_d   = move_valid ? key_code[1:0] : move_dir_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 4'b1111;
      sync2_q      <= 4'b1111;
      slot_q       <= '0;
      col_idx_q    <= 2'd0;
      frame_q      <= '0;
      frame_done_q <= 1'b0;
      move_dir_q   <= 2'd0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      slot_q       <= slot_d;
      col_idx_q    <= col_idx_d;
      frame_q      <= frame_d;
      frame_done_q <= frame_done_d;
      move_dir_q   <= move_dir_d;
    end
  end

  assign col = ~(4'b0001 << col_idx_q);

  keypad_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_done (frame_done_q),
    .frame      (frame_q),
    .accept     (key_valid),
    .code       (key_code),
    .held       (key_held)
  );

  // Direction keys occupy column 0, so a move is any code below 4.
  assign move_valid = key_valid && (key_code[3:2] == 2'b00);
  assign move_dir   = move_valid ? key_code[1:0] : move_dir_q;

endmodule
